i2c_slave_regfile: RTL

Parametrised I2C slave that replaces the fixed single-byte slave with an addressed register file.
- Samples an oversampled, open-drain SCL/SDA bus on the system clock `clk`.
- Supports 7-bit addressing, a register pointer with auto-increment, multi-byte writes and reads, and repeated START.
- The local host side gets a direct register access port and write-event strobes.
- Sits between the bus pads and system logic; the existing i2c_master drives it in the system bench.

---
 rtl/i2c_slave_regfile.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C slave (7-bit address) fronting an 8-bit register file with auto-incrementing pointer.
// Latency: bus inputs seen SYNC_STAGES+FILT_LEN clks after the pad; host_rdata 1 clk after host_addr.
// No backpressure: never stretches SCL; the host port accepts every cycle, bus writes win index collisions.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter int         PTR_W       = 4,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    localparam int FCW = $clog2(FILT_LEN) + 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic [FCW-1:0]         scl_cnt, sda_cnt;
    logic                   scl_f, sda_f, scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t           state, state_nx;
    logic [3:0]       bit_cnt, bit_cnt_nx;
    logic [7:0]       shreg, shreg_nx;
    logic [PTR_W-1:0] pointer, pointer_nx, ptr_inc;
    logic             rw, rw_nx;
    logic             rd_pend, rd_pend_nx;
    logic             sda_oe_nx, busy_nx, wr_strobe_nx;
    logic [PTR_W-1:0] wr_addr_nx;
    logic [7:0]       wr_data_nx;
    logic [7:0]       byte_in;
    logic             bus_we;

    logic [7:0] regs [NUM_REGS];

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Metastability synchronisers on the raw pad inputs; idle bus is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

    // Glitch filter: a line only changes after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_cnt <= '0;
            sda_cnt <= '0;
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_d   <= 1'b1;
            sda_d   <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
            if (scl_s != scl_f) begin
                if (scl_cnt == FCW'(FILT_LEN - 1)) begin
                    scl_f   <= scl_s;
                    scl_cnt <= '0;
                end else begin
                    scl_cnt <= scl_cnt + FCW'(1);
                end
            end else begin
                scl_cnt <= '0;
            end
            if (sda_s != sda_f) begin
                if (sda_cnt == FCW'(FILT_LEN - 1)) begin
                    sda_f   <= sda_s;
                    sda_cnt <= '0;
                end else begin
                    sda_cnt <= sda_cnt + FCW'(1);
                end
            end else begin
                sda_cnt <= '0;
            end
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
    assign byte_in   = {shreg[6:0], sda_f};
    assign ptr_inc   = pointer + PTR_W'(1);

    // Protocol state register and all bus-side datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            pointer   <= '0;
            rw        <= 1'b0;
            rd_pend   <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            shreg     <= shreg_nx;
            pointer   <= pointer_nx;
            rw        <= rw_nx;
            rd_pend   <= rd_pend_nx;
            sda_oe    <= sda_oe_nx;
            busy      <= busy_nx;
            wr_strobe <= wr_strobe_nx;
            wr_addr   <= wr_addr_nx;
            wr_data   <= wr_data_nx;
        end
    end

    // Next-state logic. In the ACK states bit_cnt flags whether the ACK slot has begun.
    // sda_oe is only ever updated on scl_fall so it never moves while SCL is high.
    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        shreg_nx     = shreg;
        pointer_nx   = pointer;
        rw_nx        = rw;
        rd_pend_nx   = rd_pend;
        sda_oe_nx    = sda_oe;
        busy_nx      = busy;
        wr_strobe_nx = 1'b0;
        wr_addr_nx   = wr_addr;
        wr_data_nx   = wr_data;
        bus_we       = 1'b0;

        case (state)
            IDLE: ;
            ADDR: begin
                if (scl_rise) begin
                    shreg_nx   = byte_in;
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_nx = '0;
                        // address 0 (general call) never matches
                        if (byte_in[7:1] == SLAVE_ADDR && byte_in[7:1] != 7'd0) begin
                            state_nx = ADDR_ACK;
                            busy_nx  = 1'b1;
                            rw_nx    = byte_in[0];
                        end else begin
                            state_nx = WAIT_STOP;
                            busy_nx  = 1'b0;
                        end
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    if (bit_cnt == 4'd0) begin
                        sda_oe_nx  = 1'b1;
                        bit_cnt_nx = 4'd1;
                    end else begin
                        bit_cnt_nx = '0;
                        rd_pend_nx = 1'b0;
                        if (rw) begin
                            state_nx  = READ;
                            shreg_nx  = regs[pointer];
                            sda_oe_nx = ~regs[pointer][7];
                        end else begin
                            state_nx  = PTR;
                            sda_oe_nx = 1'b0;
                        end
                    end
                end
            end
            PTR: begin
                if (scl_rise) begin
                    shreg_nx   = byte_in;
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_nx = '0;
                        if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                            pointer_nx = byte_in[PTR_W-1:0];
                            state_nx   = PTR_ACK;
                        end else begin
                            state_nx = WAIT_STOP;
                        end
                    end
                end
            end
            PTR_ACK: begin
                if (scl_fall) begin
                    if (bit_cnt == 4'd0) begin
                        sda_oe_nx  = 1'b1;
                        bit_cnt_nx = 4'd1;
                    end else begin
                        sda_oe_nx  = 1'b0;
                        bit_cnt_nx = '0;
                        state_nx   = WRITE;
                    end
                end
            end
            WRITE: begin
                if (scl_rise) begin
                    shreg_nx   = byte_in;
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_nx = '0;
                        state_nx   = WRITE_ACK;
                    end
                end
            end
            WRITE_ACK: begin
                if (scl_fall) begin
                    if (bit_cnt == 4'd0) begin
                        bus_we       = 1'b1;
                        wr_strobe_nx = 1'b1;
                        wr_addr_nx   = pointer;
                        wr_data_nx   = shreg;
                        pointer_nx   = ptr_inc;
                        sda_oe_nx    = 1'b1;
                        bit_cnt_nx   = 4'd1;
                    end else begin
                        sda_oe_nx  = 1'b0;
                        bit_cnt_nx = '0;
                        state_nx   = WRITE;
                    end
                end
            end
            READ: begin
                if (scl_fall) begin
                    if (rd_pend) begin
                        // next byte was loaded at the master ACK; present its MSB now
                        sda_oe_nx  = ~shreg[7];
                        rd_pend_nx = 1'b0;
                    end else if (bit_cnt == 4'd8) begin
                        state_nx   = READ_ACK;
                        sda_oe_nx  = 1'b0;
                        bit_cnt_nx = '0;
                    end else begin
                        shreg_nx  = {shreg[6:0], 1'b0};
                        sda_oe_nx = ~shreg[6];
                    end
                end else if (scl_rise) begin
                    bit_cnt_nx = bit_cnt + 4'd1;
                end
            end
            READ_ACK: begin
                if (scl_rise) begin
                    if (!sda_f) begin
                        pointer_nx = ptr_inc;
                        shreg_nx   = regs[ptr_inc];
                        state_nx   = READ;
                        bit_cnt_nx = '0;
                        rd_pend_nx = 1'b1;
                    end else begin
                        state_nx = WAIT_STOP;
                    end
                end
            end
            WAIT_STOP: sda_oe_nx = 1'b0;
            default:   state_nx  = IDLE;
        endcase

        // START/STOP override whatever transfer is in flight; the pointer survives.
        if (start_det) begin
            state_nx   = ADDR;
            bit_cnt_nx = '0;
            sda_oe_nx  = 1'b0;
            rd_pend_nx = 1'b0;
        end else if (stop_det) begin
            state_nx   = IDLE;
            bit_cnt_nx = '0;
            sda_oe_nx  = 1'b0;
            busy_nx    = 1'b0;
            rd_pend_nx = 1'b0;
        end
    end

    // Register file: bus commits take priority over a host write to the same index.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            host_rdata <= '0;
        end else begin
            if (host_we && !(bus_we && host_addr == pointer))
                regs[host_addr] <= host_wdata;
            if (bus_we)
                regs[pointer] <= shreg;
            host_rdata <= regs[host_addr];
        end
    end

endmodule
